local_inject_arbiter: RTL

LOCAL_INJECT_ARBITER -- requirements
Module: local_inject_arbiter

---
 rtl/local_inject_arbiter.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/local_inject_arbiter.sv
// Local-port injection arbiter: round-robin shares one router local port among
// N_REQ sources, locks a free credited VC, then streams one packet of flits.
//
// state  | meaning
// IDLE   | no owner; round-robin pick among req_i, latch dest/len
// VC_SEL | owner granted; wait for lowest allocatable and credited VC
// SEND   | emit one flit per cycle the locked VC has credit

package noc_params;
   localparam int PAYLOAD_W = 16;
   localparam int COORD_W   = 3;
   localparam int VC_NUM    = 2;
   localparam int VC_W      = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

   typedef enum logic [1:0] {
      HEAD     = 2'd0,
      BODY     = 2'd1,
      TAIL     = 2'd2,
      HEADTAIL = 2'd3
   } flit_type_t;

   typedef struct packed {
      flit_type_t           flit_type;
      logic [VC_W-1:0]      vc_id;
      logic [COORD_W-1:0]   dest_x;
      logic [COORD_W-1:0]   dest_y;
      logic [PAYLOAD_W-1:0] payload;
   } flit_t;
endpackage

module local_inject_arbiter #(
   parameter int  N_REQ     = 4,
   parameter int  MAX_LEN   = 8,
   parameter int  PAYLOAD_W = noc_params::PAYLOAD_W,
   localparam int LEN_W     = $clog2(MAX_LEN + 1),
   localparam int COORD_W   = noc_params::COORD_W,
   localparam int VC_NUM    = noc_params::VC_NUM
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [N_REQ-1:0]                    req_i,
   input  logic [N_REQ-1:0][COORD_W-1:0]       dest_x_i,
   input  logic [N_REQ-1:0][COORD_W-1:0]       dest_y_i,
   input  logic [N_REQ-1:0][LEN_W-1:0]         len_i,
   input  logic [N_REQ-1:0][PAYLOAD_W-1:0]     payload_i,
   output logic [N_REQ-1:0]                    grant_o,
   output logic [N_REQ-1:0]                    pop_o,
   output noc_params::flit_t                   data_o,
   output logic                                is_valid_o,
   input  logic [VC_NUM-1:0]                   is_on_off_i,
   input  logic [VC_NUM-1:0]                   is_allocatable_i,
   output logic                                err_o
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int VC_W  = noc_params::VC_W;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_VC_SEL = 2'd1,
      S_SEND   = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   rr_ptr_q;
   logic [IDX_W-1:0]   winner_q;
   logic [COORD_W-1:0] dest_x_q, dest_y_q;
   logic [LEN_W-1:0]   len_q;
   logic [LEN_W-1:0]   flits_left_q;
   logic [VC_W-1:0]    vc_q;

   logic               pick_found;
   logic [IDX_W-1:0]   pick_idx;
   int                 cand;
   logic [LEN_W-1:0]   pick_len;
   logic               bad_len;
   logic [LEN_W-1:0]   len_eff;

   logic [VC_NUM-1:0]  vc_eligible;
   logic               vc_found;
   logic [VC_W-1:0]    vc_pick;

   logic               flit_fire;
   logic               is_head;
   logic               is_last;

   // Round-robin search starting at rr_ptr_q, wrapping modulo N_REQ.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = 0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = (int'(rr_ptr_q) + k) % N_REQ;
         if (!pick_found && req_i[cand]) begin
            pick_found = 1'b1;
            pick_idx   = IDX_W'(cand);
         end
      end
   end

   // Zero or oversize lengths are sent as a single HEADTAIL flit.
   always_comb begin
      pick_len = len_i[pick_idx];
      bad_len  = (pick_len == '0) || (pick_len > LEN_W'(MAX_LEN));
      len_eff  = bad_len ? LEN_W'(1) : pick_len;
   end

   always_comb begin
      vc_eligible = is_allocatable_i & is_on_off_i;
      vc_found    = 1'b0;
      vc_pick     = '0;
      for (int v = VC_NUM - 1; v >= 0; v--) begin
         if (vc_eligible[v]) begin
            vc_found = 1'b1;
            vc_pick  = VC_W'(v);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      flit_fire  = 1'b0;
      grant_o    = '0;
      pop_o      = '0;
      is_valid_o = 1'b0;
      err_o      = 1'b0;
      data_o     = '0;
      is_head    = (flits_left_q == len_q);
      is_last    = (flits_left_q == LEN_W'(1));

      case (state_q)
         S_IDLE: begin
            err_o = rst && pick_found && bad_len;
            if (pick_found) begin
               state_d = S_VC_SEL;
            end
         end
         S_VC_SEL: begin
            grant_o[winner_q] = 1'b1;
            if (vc_found) begin
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            grant_o[winner_q] = 1'b1;
            flit_fire         = is_on_off_i[vc_q];
            if (flit_fire && is_last) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (flit_fire) begin
         is_valid_o     = 1'b1;
         pop_o          = grant_o;
         data_o.vc_id   = vc_q;
         data_o.payload = payload_i[winner_q];
         if (is_head) begin
            data_o.dest_x = dest_x_q;
            data_o.dest_y = dest_y_q;
         end
         if (is_head && is_last) begin
            data_o.flit_type = noc_params::HEADTAIL;
         end else if (is_head) begin
            data_o.flit_type = noc_params::HEAD;
         end else if (is_last) begin
            data_o.flit_type = noc_params::TAIL;
         end else begin
            data_o.flit_type = noc_params::BODY;
         end
      end
   end

   // flits_left_q counts down to the terminal value 1, which marks the tail.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rr_ptr_q     <= '0;
         winner_q     <= '0;
         dest_x_q     <= '0;
         dest_y_q     <= '0;
         len_q        <= '0;
         flits_left_q <= '0;
         vc_q         <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (pick_found) begin
                  winner_q     <= pick_idx;
                  dest_x_q     <= dest_x_i[pick_idx];
                  dest_y_q     <= dest_y_i[pick_idx];
                  len_q        <= len_eff;
                  flits_left_q <= len_eff;
               end
            end
            S_VC_SEL: begin
               if (vc_found) begin
                  vc_q <= vc_pick;
               end
            end
            S_SEND: begin
               if (flit_fire) begin
                  flits_left_q <= flits_left_q - LEN_W'(1);
                  if (is_last) begin
                     rr_ptr_q <= (winner_q == IDX_W'(N_REQ - 1)) ? '0 : winner_q + IDX_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
